// File: rtl/rename_pkg.sv
// Shared rename-stage types: FSM states, default sizes and the renamed-instruction record
// handed to dispatch and the ROB.
package rename_pkg;

  localparam int unsigned NUM_LOG_DEF  = 32;
  localparam int unsigned PHY_W_DEF    = 7;
  localparam int unsigned NUM_CKPT_DEF = 4;
  localparam int unsigned CKPT_W_DEF   = $clog2(NUM_CKPT_DEF);

  typedef enum logic [0:0] {
    StRun,
    StRecover
  } rn_state_e;

  typedef struct packed {
    logic [PHY_W_DEF-1:0]  rs1_phy;
    logic                  rs1_rdy;
    logic [PHY_W_DEF-1:0]  rs2_phy;
    logic                  rs2_rdy;
    logic [PHY_W_DEF-1:0]  rd_phy;
    logic [PHY_W_DEF-1:0]  old_phy;
    logic [CKPT_W_DEF-1:0] ckpt_id;
    logic                  is_branch;
  } rn_result_t;

endpackage

// File: rtl/rat_ckpt_ring.sv
// Ring of checkpoint snapshots with head/tail/count bookkeeping; oldest is released in order,
// recovery truncates the ring back to the restored slot.
module rat_ckpt_ring #(
  parameter int unsigned NUM_CKPT = 4,
  parameter int unsigned DATA_W   = 224,
  parameter int unsigned CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_rel,
  input  logic              i_rec,
  input  logic [CKPT_W-1:0] i_rec_id,
  output logic [DATA_W-1:0] o_rec_data,
  output logic [CKPT_W-1:0] o_tail,
  output logic              o_full
);

  localparam int unsigned CNT_W = CKPT_W + 1;

  logic [DATA_W-1:0] r_slot [NUM_CKPT];
  logic [CKPT_W-1:0] r_head, r_tail;
  logic [CKPT_W-1:0] w_head_d, w_tail_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              w_rel_eff;

  always_comb begin
    w_rel_eff = i_rel && (r_cnt != '0);
    w_head_d  = w_rel_eff ? r_head + CKPT_W'(1) : r_head;
    w_tail_d  = r_tail;
    w_cnt_d   = r_cnt;
    if (i_rec) begin
      // Release is applied first, so the surviving count is measured from the new head.
      w_tail_d = i_rec_id;
      w_cnt_d  = {1'b0, i_rec_id - w_head_d};
    end else begin
      if (i_push) w_tail_d = r_tail + CKPT_W'(1);
      if (i_push && !w_rel_eff) begin
        w_cnt_d = r_cnt + CNT_W'(1);
      end else if (!i_push && w_rel_eff) begin
        w_cnt_d = r_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      r_head <= w_head_d;
      r_tail <= w_tail_d;
      r_cnt  <= w_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_rec) r_slot[r_tail] <= i_push_data;
  end

  assign o_rec_data = r_slot[i_rec_id];
  assign o_tail     = r_tail;
  assign o_full     = (r_cnt == CNT_W'(NUM_CKPT));

endmodule

// File: rtl/rat_ckpt.sv
// Register alias table with per-tag ready bits, writeback wakeup and branch checkpoints
// for misprediction recovery; one rename per cycle, registered results.
module rat_ckpt
  import rename_pkg::*;
#(
  parameter int unsigned NUM_LOG  = NUM_LOG_DEF,
  parameter int unsigned PHY_W    = PHY_W_DEF,
  parameter int unsigned NUM_CKPT = NUM_CKPT_DEF,
  parameter int unsigned CKPT_W   = $clog2(NUM_CKPT),
  localparam int unsigned LOG_W   = $clog2(NUM_LOG),
  localparam int unsigned NUM_PHY = 2 ** PHY_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rn_valid,
  output logic              o_rn_ready,
  input  logic [LOG_W-1:0]  i_rn_rs1,
  input  logic [LOG_W-1:0]  i_rn_rs2,
  input  logic [LOG_W-1:0]  i_rn_rd,
  input  logic              i_rn_rd_we,
  input  logic              i_rn_is_branch,
  input  logic [PHY_W-1:0]  i_fl_phy,
  input  logic              i_fl_empty,
  output logic              o_fl_pop,
  output logic              o_out_valid,
  output logic [PHY_W-1:0]  o_out_rs1_phy,
  output logic [PHY_W-1:0]  o_out_rs2_phy,
  output logic              o_out_rs1_rdy,
  output logic              o_out_rs2_rdy,
  output logic [PHY_W-1:0]  o_out_rd_phy,
  output logic [PHY_W-1:0]  o_out_old_phy,
  output logic [CKPT_W-1:0] o_out_ckpt_id,
  output logic              o_out_is_branch,
  input  logic              i_wb_valid,
  input  logic [PHY_W-1:0]  i_wb_phy,
  input  logic              i_rel_valid,
  input  logic              i_rec_valid,
  input  logic [CKPT_W-1:0] i_rec_ckpt
);

  logic [NUM_LOG-1:0][PHY_W-1:0] r_map;
  logic [NUM_LOG-1:0][PHY_W-1:0] w_map_upd;
  logic [NUM_LOG*PHY_W-1:0]      w_map_rec;
  logic [NUM_PHY-1:0]            r_ready;
  rn_state_e                     r_state;

  logic              w_alloc, w_accept, w_ckpt_full, w_push;
  logic [CKPT_W-1:0] w_tail;
  logic [PHY_W-1:0]  w_rs1_phy, w_rs2_phy;
  logic              w_rs1_rdy, w_rs2_rdy;

  assign w_alloc    = i_rn_rd_we && (i_rn_rd != '0);
  assign o_rn_ready = i_rst_n && (r_state == StRun) && !i_rec_valid &&
                      !(w_alloc && i_fl_empty) && !(i_rn_is_branch && w_ckpt_full);
  assign w_accept   = i_rn_valid && o_rn_ready;
  assign o_fl_pop   = w_accept && w_alloc;
  assign w_push     = w_accept && i_rn_is_branch;

  always_comb begin
    w_rs1_phy = (i_rn_rs1 == '0) ? '0 : r_map[i_rn_rs1];
    w_rs2_phy = (i_rn_rs2 == '0) ? '0 : r_map[i_rn_rs2];
    w_rs1_rdy = (i_rn_rs1 == '0) || r_ready[w_rs1_phy] || (i_wb_valid && i_wb_phy == w_rs1_phy);
    w_rs2_rdy = (i_rn_rs2 == '0) || r_ready[w_rs2_phy] || (i_wb_valid && i_wb_phy == w_rs2_phy);
    w_map_upd = r_map;
    if (w_alloc) w_map_upd[i_rn_rd] = i_fl_phy;
  end

  rat_ckpt_ring #(
    .NUM_CKPT (NUM_CKPT),
    .DATA_W   (NUM_LOG * PHY_W),
    .CKPT_W   (CKPT_W)
  ) u_ring (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_data (w_map_upd),
    .i_rel       (i_rel_valid),
    .i_rec       (i_rec_valid),
    .i_rec_id    (i_rec_ckpt),
    .o_rec_data  (w_map_rec),
    .o_tail      (w_tail),
    .o_full      (w_ckpt_full)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_LOG; i++) r_map[i] <= PHY_W'(i);
    end else if (i_rec_valid) begin
      r_map <= w_map_rec;
    end else if (o_fl_pop) begin
      r_map <= w_map_upd;
    end
  end

  // Allocation is written after wakeup so a same-tag collision leaves the tag not ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_PHY; i++) r_ready[i] <= (i < NUM_LOG);
    end else begin
      if (i_wb_valid) r_ready[i_wb_phy] <= 1'b1;
      if (o_fl_pop)   r_ready[i_fl_phy] <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= StRun;
      o_out_valid     <= 1'b0;
      o_out_rs1_phy   <= '0;
      o_out_rs2_phy   <= '0;
      o_out_rs1_rdy   <= 1'b0;
      o_out_rs2_rdy   <= 1'b0;
      o_out_rd_phy    <= '0;
      o_out_old_phy   <= '0;
      o_out_ckpt_id   <= '0;
      o_out_is_branch <= 1'b0;
    end else begin
      // A restore in either state (re)starts the one-cycle recovery window.
      r_state     <= i_rec_valid ? StRecover : StRun;
      o_out_valid <= w_accept;
      if (w_accept) begin
        o_out_rs1_phy   <= w_rs1_phy;
        o_out_rs2_phy   <= w_rs2_phy;
        o_out_rs1_rdy   <= w_rs1_rdy;
        o_out_rs2_rdy   <= w_rs2_rdy;
        o_out_rd_phy    <= w_alloc ? i_fl_phy : '0;
        o_out_old_phy   <= w_alloc ? r_map[i_rn_rd] : '0;
        o_out_ckpt_id   <= w_tail;
        o_out_is_branch <= i_rn_is_branch;
      end
    end
  end

endmodule

// File: tb/tb_rat_ckpt.sv
// Directed bench for rat_ckpt: rename lookup, wakeup bypass, checkpoint ring and recovery.
module tb_rat_ckpt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rn_valid, rn_ready, rn_rd_we, rn_is_branch;
  logic [4:0] rn_rs1, rn_rs2, rn_rd;
  logic [6:0] fl_phy, wb_phy;
  logic       fl_empty, fl_pop;
  logic       out_valid, out_rs1_rdy, out_rs2_rdy, out_is_branch;
  logic [6:0] out_rs1_phy, out_rs2_phy, out_rd_phy, out_old_phy;
  logic [1:0] out_ckpt_id, rec_ckpt;
  logic       wb_valid, rel_valid, rec_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rat_ckpt u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_rn_valid      (rn_valid),
    .o_rn_ready      (rn_ready),
    .i_rn_rs1        (rn_rs1),
    .i_rn_rs2        (rn_rs2),
    .i_rn_rd         (rn_rd),
    .i_rn_rd_we      (rn_rd_we),
    .i_rn_is_branch  (rn_is_branch),
    .i_fl_phy        (fl_phy),
    .i_fl_empty      (fl_empty),
    .o_fl_pop        (fl_pop),
    .o_out_valid     (out_valid),
    .o_out_rs1_phy   (out_rs1_phy),
    .o_out_rs2_phy   (out_rs2_phy),
    .o_out_rs1_rdy   (out_rs1_rdy),
    .o_out_rs2_rdy   (out_rs2_rdy),
    .o_out_rd_phy    (out_rd_phy),
    .o_out_old_phy   (out_old_phy),
    .o_out_ckpt_id   (out_ckpt_id),
    .o_out_is_branch (out_is_branch),
    .i_wb_valid      (wb_valid),
    .i_wb_phy        (wb_phy),
    .i_rel_valid     (rel_valid),
    .i_rec_valid     (rec_valid),
    .i_rec_ckpt      (rec_ckpt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rn_valid     = 1'b0;
    rn_rd_we     = 1'b0;
    rn_is_branch = 1'b0;
    wb_valid     = 1'b0;
    rel_valid    = 1'b0;
    rec_valid    = 1'b0;
  endtask

  task automatic ren(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic we, input logic br, input logic [6:0] fl);
    idle();
    rn_valid     = 1'b1;
    rn_rs1       = rs1;
    rn_rs2       = rs2;
    rn_rd        = rd;
    rn_rd_we     = we;
    rn_is_branch = br;
    fl_phy       = fl;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    idle();
    rn_rs1   = '0;
    rn_rs2   = '0;
    rn_rd    = '0;
    fl_phy   = '0;
    fl_empty = 1'b0;
    wb_phy   = '0;
    rec_ckpt = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_phy", out_rd_phy, 0);
    check("rst_fl_pop", fl_pop, 0);
    check("rst_rn_ready", rn_ready, 0);
    rst_n = 1'b1;
    tick();

    // add x3 <- x1, x2
    ren(1, 2, 3, 1, 0, 40);
    check("add_fl_pop", fl_pop, 1);
    check("add_rn_ready", rn_ready, 1);
    tick();
    check("add_valid", out_valid, 1);
    check("add_rs1", out_rs1_phy, 1);
    check("add_rs1_rdy", out_rs1_rdy, 1);
    check("add_rs2", out_rs2_phy, 2);
    check("add_rs2_rdy", out_rs2_rdy, 1);
    check("add_rd", out_rd_phy, 40);
    check("add_old", out_old_phy, 3);

    ren(3, 0, 0, 0, 0, 0);
    check("rd3_fl_pop", fl_pop, 0);
    tick();
    check("rd3_rs1", out_rs1_phy, 40);
    check("rd3_rs1_rdy", out_rs1_rdy, 0);
    check("rd3_rs2_x0", out_rs2_phy, 0);
    check("rd3_rs2_rdy", out_rs2_rdy, 1);
    check("rd3_rd", out_rd_phy, 0);

    // rd == rs1 sees the pre-update mapping
    ren(5, 0, 5, 1, 0, 41);
    tick();
    check("x5_rs1_old", out_rs1_phy, 5);
    check("x5_rd", out_rd_phy, 41);
    check("x5_old", out_old_phy, 5);

    idle();
    tick();
    check("idle_valid", out_valid, 0);
    check("idle_hold_rd", out_rd_phy, 41);

    ren(5, 0, 0, 0, 0, 0);
    wb_valid = 1'b1;
    wb_phy   = 41;
    tick();
    check("byp_rs1", out_rs1_phy, 41);
    check("byp_rs1_rdy", out_rs1_rdy, 1);
    ren(5, 0, 0, 0, 0, 0);
    tick();
    check("wake_rs1_rdy", out_rs1_rdy, 1);

    ren(0, 0, 0, 1, 0, 42);
    check("x0_fl_pop", fl_pop, 0);
    tick();
    check("x0_valid", out_valid, 1);
    check("x0_rd", out_rd_phy, 0);
    check("x0_old", out_old_phy, 0);

    // fill the checkpoint ring
    for (int i = 0; i < 4; i++) begin
      ren(0, 0, 0, 0, 1, 0);
      check("br_ready", rn_ready, 1);
      tick();
      check("br_id", out_ckpt_id, i);
      check("br_is_branch", out_is_branch, 1);
    end
    ren(0, 0, 0, 0, 1, 0);
    rel_valid = 1'b1;
    #1;
    check("full_stall", rn_ready, 0);
    tick();
    check("stall_valid", out_valid, 0);
    rel_valid = 1'b0;
    #1;
    check("wrap_ready", rn_ready, 1);
    tick();
    check("wrap_id", out_ckpt_id, 0);

    // fresh state for the recovery scenario
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    ren(0, 0, 0, 0, 1, 0);
    tick();
    check("rb_id0", out_ckpt_id, 0);
    ren(0, 0, 0, 0, 1, 0);
    tick();
    check("rb_id1", out_ckpt_id, 1);
    ren(0, 0, 7, 1, 0, 50);
    tick();
    check("x7_rd", out_rd_phy, 50);
    check("x7_old", out_old_phy, 7);

    ren(0, 0, 8, 1, 0, 60);
    rec_valid = 1'b1;
    rec_ckpt  = 1;
    #1;
    check("rec_rn_ready", rn_ready, 0);
    check("rec_fl_pop", fl_pop, 0);
    tick();
    check("rec_drop_valid", out_valid, 0);
    rec_valid = 1'b0;
    #1;
    check("recover_rn_ready", rn_ready, 0);
    tick();
    ren(7, 8, 0, 0, 0, 0);
    check("run_rn_ready", rn_ready, 1);
    tick();
    check("rec_x7", out_rs1_phy, 7);
    check("rec_x8", out_rs2_phy, 8);

    // restored count is 1, so ids 1..3 fit and then the ring is full
    ren(0, 0, 7, 1, 0, 50);
    tick();
    for (int i = 1; i < 4; i++) begin
      ren(0, 0, 0, 0, 1, 0);
      tick();
      check("rec_br_id", out_ckpt_id, i);
    end
    ren(0, 0, 0, 0, 1, 0);
    check("rec_full_stall", rn_ready, 0);

    // reset in the middle of recovery
    idle();
    rec_valid = 1'b1;
    rec_ckpt  = 2;
    tick();
    check("rec2_valid", out_valid, 0);
    check("rec2_hold_id", out_ckpt_id, 3);
    rec_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_id", out_ckpt_id, 0);
    check("async_is_branch", out_is_branch, 0);
    rst_n = 1'b1;
    #1;
    ren(7, 0, 0, 0, 0, 0);
    check("post_rst_ready", rn_ready, 1);
    tick();
    check("post_rst_x7", out_rs1_phy, 7);
    check("post_rst_x7_rdy", out_rs1_rdy, 1);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
